// File: rtl/alu_pkg.sv
// Shared opcode encoding and flag bit positions for the execute-stage ALU.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_adder.sv
// Single DW-bit adder shared by ADD and SUB; b arrives already inverted for SUB.
module alu_adder #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  output logic [DW-1:0] sum,
  output logic          cout,
  output logic          ovf
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};

  // Signed overflow: like-signed inputs giving a result of the other sign.
  assign ovf = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);

endmodule

// File: rtl/alu.sv
// Execute-stage ALU with registered result (ADD/SUB/AND/OR).
// Define ALU_FLAGS_EN to add the registered {N,Z,C,V} flags port.
module alu
  import alu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic [1:0]    alu_control,
`ifdef ALU_FLAGS_EN
  output logic [3:0]    flags,
`endif
  output logic [DW-1:0] y
);

  logic          is_sub;
  logic [DW-1:0] b_mux;
  logic [DW-1:0] sum;
  logic [DW-1:0] y_next;

  // SUB is A + ~B + 1, so the opcode LSB doubles as invert select and carry-in.
  assign is_sub = alu_control[0];
  assign b_mux  = is_sub ? ~B : B;

`ifdef ALU_FLAGS_EN
  logic       cout;
  logic       ovf;
  logic [3:0] flags_next;

  alu_adder #(.DW(DW)) u_adder (
    .a    (A),
    .b    (b_mux),
    .cin  (is_sub),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );
`else
  alu_adder #(.DW(DW)) u_adder (
    .a    (A),
    .b    (b_mux),
    .cin  (is_sub),
    .sum  (sum),
    .cout (),
    .ovf  ()
  );
`endif

  always_comb begin
    y_next = sum;
    case (alu_op_e'(alu_control))
      ALU_ADD: y_next = sum;
      ALU_SUB: y_next = sum;
      ALU_AND: y_next = A & B;
      ALU_OR:  y_next = A | B;
      default: y_next = sum;
    endcase
  end

`ifdef ALU_FLAGS_EN
  // Carry and overflow only mean something for the arithmetic ops.
  always_comb begin
    flags_next         = '0;
    flags_next[FLAG_N] = y_next[DW-1];
    flags_next[FLAG_Z] = (y_next == '0);
    flags_next[FLAG_C] = ~alu_control[1] & cout;
    flags_next[FLAG_V] = ~alu_control[1] & ovf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags <= '0;
    else     flags <= flags_next;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) y <= '0;
    else     y <= y_next;
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, async reset sequence, random vs. model.
module tb_alu;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic [DW-1:0] A, B;
  logic [1:0]    alu_control;
  logic [DW-1:0] y;
  logic [3:0]    flags;

  alu #(.DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .A           (A),
    .B           (B),
    .alu_control (alu_control),
`ifdef ALU_FLAGS_EN
    .flags       (flags),
`endif
    .y           (y)
  );

`ifndef ALU_FLAGS_EN
  assign flags = 4'h0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [1:0]    op;
    logic [DW-1:0] exp_y;
    logic [3:0]    exp_f;
  } vec_t;

  typedef struct {
    logic [DW-1:0] y;
    logic [3:0]    f;
    int            tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check_val(input string name, input int tag, input logic [DW-1:0] got,
                           input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, tag, got, exp);
    end
  endtask

  task automatic check_flags(input string name, input int tag, input logic [3:0] got,
                             input logic [3:0] exp);
`ifdef ALU_FLAGS_EN
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s_flags[%0d]: got %b, expected %b", name, tag, got, exp);
    end
`endif
  endtask

  // Independent reference: uses plain subtraction and magnitude compare.
  function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [1:0] op);
    exp_t          e;
    logic [DW:0]   wide;
    e.tag = 0;
    e.f   = 4'h0;
    case (op)
      2'b00: begin
        wide   = {1'b0, a} + {1'b0, b};
        e.y    = wide[DW-1:0];
        e.f[1] = wide[DW];
        e.f[0] = (a[DW-1] == b[DW-1]) && (e.y[DW-1] != a[DW-1]);
      end
      2'b01: begin
        e.y    = a - b;
        e.f[1] = (a >= b);
        e.f[0] = (a[DW-1] != b[DW-1]) && (e.y[DW-1] != a[DW-1]);
      end
      2'b10:   e.y = a & b;
      default: e.y = a | b;
    endcase
    e.f[3] = e.y[DW-1];
    e.f[2] = (e.y == '0);
    return e;
  endfunction

  // Drive at negedge, push expectation; sample just after the following posedge.
  task automatic apply(input string name, input int tag, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [1:0] op,
                       input logic [DW-1:0] ey, input logic [3:0] ef);
    exp_t e;
    @(negedge clk);
    A = a; B = b; alu_control = op;
    e.y = ey; e.f = ef; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_val(name, e.tag, y, e.y);
    check_flags(name, e.tag, flags, e.f);
  endtask

  vec_t vt[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt = '{
      '{32'd0,        32'd5,  2'b00, 32'd5,        4'b0000},
      '{32'd0,        32'd5,  2'b11, 32'd5,        4'b0000},
      '{32'd0,        32'd5,  2'b10, 32'd0,        4'b0100},
      '{32'd0,        32'd5,  2'b01, 32'hFFFFFFFB, 4'b1000},
      '{32'd10,       32'd20, 2'b00, 32'd30,       4'b0000},
      '{32'd10,       32'd20, 2'b11, 32'd30,       4'b0000},
      '{32'd10,       32'd20, 2'b10, 32'd0,        4'b0100},
      '{32'd10,       32'd20, 2'b01, 32'hFFFFFFF6, 4'b1000},
      '{32'hFFFFFFFF, 32'd1,  2'b00, 32'd0,        4'b0110},
      '{32'd0,        32'd1,  2'b01, 32'hFFFFFFFF, 4'b1000},
      '{32'h7FFFFFFF, 32'd1,  2'b00, 32'h80000000, 4'b1001},
      '{32'h7FFFFFFF, 32'd1,  2'b10, 32'd1,        4'b0000},
      '{32'h7FFFFFFF, 32'd1,  2'b11, 32'h7FFFFFFF, 4'b0000},
      '{32'd5,        32'd5,  2'b01, 32'd0,        4'b0110},
      '{32'h80000000, 32'd1,  2'b01, 32'h7FFFFFFF, 4'b0011}
    };

    rst = 1'b1; A = '0; B = '0; alu_control = 2'b00;
    @(posedge clk); #1;
    check_val("reset_y", 0, y, '0);
    check_flags("reset", 0, flags, 4'h0);
    @(negedge clk); #2;
    rst = 1'b0;

    foreach (vt[i]) apply("vec", i, vt[i].a, vt[i].b, vt[i].op, vt[i].exp_y, vt[i].exp_f);

    // Async reset mid-run with y nonzero (last vector left 0x7FFFFFFF).
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_val("async_rst_y", 0, y, '0);
    check_flags("async_rst", 0, flags, 4'h0);
    A = 32'd3; B = 32'd4; alu_control = 2'b00;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check_val("rst_hold_y", k, y, '0);
    end
    @(negedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("rst_release_y", 0, y, 32'd7);
    check_flags("rst_release", 0, flags, 4'b0000);

    for (int i = 0; i < 10000; i++) begin
      logic [DW-1:0] ra, rb;
      logic [1:0]    rop;
      exp_t          e;
      ra  = $urandom();
      rb  = $urandom();
      rop = 2'($urandom_range(0, 3));
      if (i % 16 == 0) rb = ra;
      e = model(ra, rb, rop);
      apply("rand", i, ra, rb, rop, e.y, e.f);
    end

    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
